// File: rtl/apb_reg_completer.sv
// APB4 completer over a small register bank: programmable wait states, byte-strobed writes, PSLVERR.
// Optional: define APB_PROT_CHECK_EN to reject unprivileged (pprot[0]==0) writes.
module apb_reg_completer #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_EXT = DATA_WIDTH'(ID_VALUE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic                  err_q, err_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  prot_err;
    logic                  setup_err;
    logic                  go_resp;

`ifdef APB_PROT_CHECK_EN
    assign prot_err = pwrite && !pprot[0];
    logic [1:0] unused_prot;
    assign unused_prot = pprot[2:1];
`else
    assign prot_err = 1'b0;
    logic [2:0] unused_prot;
    assign unused_prot = pprot;
`endif

    assign word_addr = paddr >> OFF_W;
    assign setup_err = (paddr[OFF_W-1:0] != '0)
                    || (word_addr >= ADDR_WIDTH'(NUM_REGS))
                    || (pwrite && (word_addr == '0))
                    || prot_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        go_resp   = 1'b0;
        regs_d    = regs_q;

        case (state_q)
            ST_IDLE: begin
                // A setup with penable already high is a protocol violation and is ignored.
                if (pselx && !penable) begin
                    idx_d   = word_addr[IDX_W-1:0];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    err_d   = setup_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(pselx && penable)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (pselx && penable && pready_q && write_q && !err_q) begin
                    for (int b = 0; b < NB; b++) begin
                        if (strb_q[b]) regs_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response is computed from the transfer's latched (or just-latching) attributes.
        if (go_resp) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            prdata_d  = (err_d || write_d) ? '0 : regs_q[idx_d];
        end

        regs_d[0] = ID_EXT;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            regs_q[0] <= ID_EXT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench for apb_reg_completer: three instances with 0, 3 and 5 wait states share one APB bus.
module tb_apb_reg_completer;
    localparam logic [31:0] ID = 32'hA5B0_0001;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [7:0]  cyc;
    } resp_t;

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } txn_t;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [2:0]  rdy;
    logic [2:0]  serr;
    logic [31:0] rdata [3];

    logic [31:0] mdl [3][8];
    resp_t       exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 pclk = ~pclk;

    apb_reg_completer #(.WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .presetn(presetn), .pselx(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(rdy[0]), .prdata(rdata[0]), .pslverr(serr[0]));
    apb_reg_completer #(.WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .presetn(presetn), .pselx(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(rdy[1]), .prdata(rdata[1]), .pslverr(serr[1]));
    apb_reg_completer #(.WAIT_CYCLES(5)) u_w5 (
        .pclk(pclk), .presetn(presetn), .pselx(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(rdy[2]), .prdata(rdata[2]), .pslverr(serr[2]));

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    function automatic txn_t mk(input int d, input bit wr, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] s, input logic [2:0] p);
        txn_t t;
        t.d = d; t.wr = wr; t.addr = a; t.wdata = w; t.strb = s; t.prot = p;
        return t;
    endfunction

    function automatic void mdl_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++) mdl[d][i] = (i == 0) ? ID : 32'h0;
    endfunction

    // Reference model: expected response, and register update on a good write.
    function automatic resp_t model(input txn_t t);
        resp_t       r;
        logic [29:0] idx;
        logic        e;
        idx = t.addr[31:2];
        e = (t.addr[1:0] != 2'b00) || (idx >= 30'd8) || (t.wr && idx == 30'd0);
`ifdef APB_PROT_CHECK_EN
        if (t.wr && !t.prot[0]) e = 1'b1;
`endif
        r.err = e;
        r.cyc = 8'(wait_of(t.d) + 1);
        r.rd  = '0;
        if (!e && !t.wr) r.rd = mdl[t.d][idx[2:0]];
        if (!e && t.wr)
            for (int b = 0; b < 4; b++)
                if (t.strb[b]) mdl[t.d][idx[2:0]][8*b +: 8] = t.wdata[8*b +: 8];
        return r;
    endfunction

    task automatic run_txn(input txn_t t, output resp_t obs);
        int cyc;
        psel = '0; psel[t.d] = 1'b1; penable = 1'b0;
        pwrite = t.wr; paddr = t.addr; pwdata = t.wdata; pstrb = t.strb; pprot = t.prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!rdy[t.d] && cyc < 40) begin
            @(posedge pclk); #1;
            cyc++;
        end
        obs.rd = rdata[t.d]; obs.err = serr[t.d]; obs.cyc = 8'(cyc);
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
    endtask

    task automatic test_reset();
        #1 presetn = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({rdy[d], serr[d], rdata[d]} !== 34'b0)
                $display("FAIL reset[%0d]: got pready=%b pslverr=%b prdata=%h, want all 0", d, rdy[d], serr[d], rdata[d]);
            else n_pass++;
        end
        mdl_reset();
        @(posedge pclk); #1;
        presetn = 1'b1;
    endtask

    task automatic test_basic();
        txn_t q[$]; resp_t obs, e;
        q.push_back(mk(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001));
        q.push_back(mk(0, 0, 32'h4, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 0, 32'h0, 32'h0, 4'hF, 3'b000));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL basic[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_strobes();
        txn_t q[$]; resp_t obs, e;
        q.push_back(mk(0, 1, 32'h4, 32'h11223344, 4'hF, 3'b001));
        q.push_back(mk(0, 1, 32'h4, 32'hAABBCCDD, 4'b0101, 3'b001));
        q.push_back(mk(0, 0, 32'h4, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 1, 32'h4, 32'hFFFFFFFF, 4'b0000, 3'b001));
        q.push_back(mk(0, 0, 32'h4, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 1, 32'h1C, 32'h55667788, 4'b1010, 3'b001));
        q.push_back(mk(0, 0, 32'h1C, 32'h0, 4'h0, 3'b001));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL strobes[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        txn_t q[$]; resp_t obs, e;
        q.push_back(mk(0, 0, 32'h20, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 0, 32'h6, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 1, 32'h0, 32'hDEAD0000, 4'hF, 3'b001));
        q.push_back(mk(0, 1, 32'h6, 32'hCAFECAFE, 4'hF, 3'b001));
        q.push_back(mk(0, 1, 32'h20, 32'hCAFECAFE, 4'hF, 3'b001));
        q.push_back(mk(0, 0, 32'h0, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 0, 32'h4, 32'h0, 4'h0, 3'b001));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL errors[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        txn_t q[$]; resp_t obs, e;
        q.push_back(mk(1, 0, 32'h0, 32'h0, 4'h0, 3'b000));
        q.push_back(mk(2, 0, 32'h0, 32'h0, 4'h0, 3'b000));
        q.push_back(mk(1, 0, 32'h24, 32'h0, 4'h0, 3'b000));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL wait[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        txn_t q[$]; resp_t obs, e;
        for (int i = 1; i < 8; i++)
            q.push_back(mk(1, 1, 32'(i * 4), $urandom, 4'($urandom_range(0, 15)), 3'b001));
        for (int i = 1; i < 8; i++)
            q.push_back(mk(1, 0, 32'(i * 4), 32'h0, 4'h0, 3'b001));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL b2b[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
            n_checks++;
            if ({rdy[1], serr[1], rdata[1]} !== 34'b0)
                $display("FAIL b2b_drop[%0d]: got pready=%b pslverr=%b prdata=%h, want all 0", i, rdy[1], serr[1], rdata[1]);
            else n_pass++;
        end
    endtask

    task automatic test_protocol_violation();
        logic saw = 1'b0;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b001;
        repeat (4) begin
            @(posedge pclk); #1;
            saw = saw | rdy[0];
        end
        psel = '0; penable = 1'b0;
        n_checks++;
        if (saw !== 1'b0) $display("FAIL proto_violation: got pready=%b, want 0", saw);
        else n_pass++;
    endtask

    task automatic test_abort();
        txn_t q[$]; resp_t obs, e;
        logic saw = 1'b0;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        saw = saw | rdy[2];
        penable = 1'b1;
        @(posedge pclk); #1;
        saw = saw | rdy[2];
        psel = '0; penable = 1'b0;
        repeat (10) begin
            @(posedge pclk); #1;
            saw = saw | rdy[2];
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL abort_pready: got %b, want 0", saw);
        else n_pass++;
        q.push_back(mk(2, 0, 32'h8, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(2, 1, 32'h8, 32'h0BADF00D, 4'hF, 3'b001));
        q.push_back(mk(2, 0, 32'h8, 32'h0, 4'h0, 3'b001));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL abort[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_prot();
        txn_t q[$]; resp_t obs, e;
        q.push_back(mk(0, 1, 32'h8, 32'hAAAA5555, 4'hF, 3'b000));
        q.push_back(mk(0, 0, 32'h8, 32'h0, 4'h0, 3'b000));
        q.push_back(mk(0, 1, 32'h8, 32'h13572468, 4'hF, 3'b001));
        q.push_back(mk(0, 0, 32'h8, 32'h0, 4'h0, 3'b000));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL prot[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        txn_t q[$]; resp_t obs, e;
        int n = 0;
        psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        while (!rdy[1] && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        presetn = 1'b0;
        #1;
        n_checks++;
        if ({rdy[1], serr[1], rdata[1]} !== 34'b0)
            $display("FAIL reset_mid: got pready=%b pslverr=%b prdata=%h, want all 0", rdy[1], serr[1], rdata[1]);
        else n_pass++;
        psel = '0; penable = 1'b0;
        mdl_reset();
        @(posedge pclk); #1;
        presetn = 1'b1;
        q.push_back(mk(1, 0, 32'h4, 32'h0, 4'h0, 3'b001));
        q.push_back(mk(0, 0, 32'h8, 32'h0, 4'h0, 3'b001));
        foreach (q[i]) begin
            exp_q.push_back(model(q[i]));
            run_txn(q[i], obs);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL reset_regs[%0d]: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d", i, obs.rd, obs.err, obs.cyc, e.rd, e.err, e.cyc);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_errors();
        test_wait_states();
        test_back_to_back();
        test_protocol_violation();
        test_abort();
        test_prot();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
